// File: rtl/lrf_fuse_seq.sv
// lrf_fuse_seq: sequencing and stream control for the local-region fusion pipeline.
// It counts beats and frames of the incoming AXI stream and drives the external
// Sobel/HSSIM/Gauss/fusion datapath. A tag delay line, matched to the datapath
// latency, marks which results belong to the last frame of a fusion window. A
// small output FIFO holds those results so that m_axis_tready is decoupled from
// s_axis_tready.
// Optional feature macro: LRF_SEQ_FLUSH_EN adds a FLUSH state. That state issues
// bubble advances to drain the datapath while the input is idle at a frame boundary.
module lrf_fuse_seq #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int CHANNELS        = 1,
  parameter int IMAGE_DIM       = 64,
  parameter int N_FUSE_COUNT    = 4,
  parameter int PIPELINE_DELAY  = 23,
  parameter int OUT_FIFO_DEPTH  = 4,
  localparam int DATA_WIDTH = 8 * PIXELS_PER_BEAT * CHANNELS,
  localparam int BEATS      = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT,
  localparam int FRAME_W    = (N_FUSE_COUNT < 1) ? 1 : N_FUSE_COUNT,
  localparam int BEAT_W     = (BEATS < 2) ? 1 : $clog2(BEATS)
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  dp_advance,
  output logic                  dp_in_valid,
  output logic [DATA_WIDTH-1:0] dp_in_data,
  output logic [FRAME_W-1:0]    dp_frame_idx,
  output logic [BEAT_W-1:0]     dp_beat_idx,
  output logic                  dp_first,
  input  logic [DATA_WIDTH-1:0] dp_result,
  output logic                  err_framing
);

  localparam int FUSE_COUNT = 1 << N_FUSE_COUNT;
  localparam int D          = PIPELINE_DELAY;
  localparam int AW         = $clog2(OUT_FIFO_DEPTH);
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FUSE_COUNT - 1);
  localparam logic [AW:0]        FIFO_MAX   = (AW + 1)'(OUT_FIFO_DEPTH);

  logic [BEAT_W-1:0]     beat_cnt;
  logic [FRAME_W-1:0]    frame_cnt;
  logic [D-1:0]          tag_emit;
  logic [D-1:0]          tag_last;
  logic [DATA_WIDTH-1:0] fifo_data [OUT_FIFO_DEPTH];
  logic [OUT_FIFO_DEPTH-1:0] fifo_last;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           fifo_cnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  adv_ok;
  logic                  accept;
  logic                  bubble;
  logic                  new_emit;
  logic                  new_last;

  // The stall decision is made only on an emitting result that has nowhere to go.
  // A pop in the same cycle frees a slot, so that case does not stall.
  assign fifo_full     = (fifo_cnt == FIFO_MAX);
  assign fifo_empty    = (fifo_cnt == '0);
  assign m_axis_tvalid = ~fifo_empty;
  assign fifo_pop      = m_axis_tvalid & m_axis_tready;
  assign adv_ok        = ~(tag_emit[D-1] & fifo_full & ~fifo_pop);
  assign s_axis_tready = adv_ok & ~s_axis_areset;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign dp_advance    = accept | bubble;
  assign dp_in_valid   = accept;
  assign dp_in_data    = accept ? s_axis_tdata : '0;
  assign dp_frame_idx  = frame_cnt;
  assign dp_beat_idx   = beat_cnt;
  assign dp_first      = (frame_cnt == '0);
  assign new_emit      = accept & (frame_cnt == LAST_FRAME);
  assign new_last      = new_emit & (beat_cnt == LAST_BEAT);
  assign fifo_push     = dp_advance & tag_emit[D-1];
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_data[rd_ptr];
  assign m_axis_tlast  = ~fifo_empty & fifo_last[rd_ptr];

`ifdef LRF_SEQ_FLUSH_EN
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]   state;
  logic [D-1:0] tag_valid;
  logic         any_valid;

  assign any_valid = |tag_valid;
  assign bubble    = (state == ST_FLUSH) & ~s_axis_tvalid & adv_ok & any_valid & ~s_axis_areset;

  // Track which delay-line stages hold real beats, so a flush stops once the line is empty.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      tag_valid <= '0;
    end else if (dp_advance) begin
      for (int i = D - 1; i > 0; i--) begin
        tag_valid[i] <= tag_valid[i-1];
      end
      tag_valid[0] <= accept;
    end
  end

  // Drain at a frame boundary when the input goes idle. New input cancels the drain.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (~s_axis_tvalid && beat_cnt == '0 && any_valid) state <= ST_FLUSH;
        ST_FLUSH: if (~any_valid || s_axis_tvalid) state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end
`else
  assign bubble = 1'b0;
`endif

  // The beat counter decides frame boundaries. tlast is only compared against it.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      beat_cnt  <= '0;
      frame_cnt <= '0;
    end else if (accept) begin
      if (beat_cnt == LAST_BEAT) begin
        beat_cnt  <= '0;
        frame_cnt <= (frame_cnt == LAST_FRAME) ? '0 : frame_cnt + 1'b1;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Sticky flag for any tlast that disagrees with the beat counter.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      err_framing <= 1'b0;
    end else if (accept && (s_axis_tlast != (beat_cnt == LAST_BEAT))) begin
      err_framing <= 1'b1;
    end
  end

  // The tag delay line moves in step with the datapath, so stage D-1 lines up with dp_result.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      tag_emit <= '0;
      tag_last <= '0;
    end else if (dp_advance) begin
      for (int i = D - 1; i > 0; i--) begin
        tag_emit[i] <= tag_emit[i-1];
        tag_last[i] <= tag_last[i-1];
      end
      tag_emit[0] <= new_emit;
      tag_last[0] <= new_last;
    end
  end

  // FIFO storage has no reset. Reads are masked while the FIFO is empty.
  always_ff @(posedge s_axis_aclk) begin
    if (fifo_push) begin
      fifo_data[wr_ptr] <= dp_result;
      fifo_last[wr_ptr] <= tag_last[D-1];
    end
  end

  // FIFO pointers and occupancy. A push and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_lrf_fuse_seq.sv
// Testbench for lrf_fuse_seq, configured with BEATS=4, a 2-frame window and D=3.
// The expected output stream is built from the frame/beat position of every accepted beat.
module tb_lrf_fuse_seq;

  localparam int PPB    = 16;
  localparam int CH     = 1;
  localparam int DIM    = 8;
  localparam int NF     = 1;
  localparam int D      = 3;
  localparam int DEPTH  = 4;
  localparam int DW     = 8 * PPB * CH;
  localparam int BEATS  = DIM * DIM / PPB;
  localparam int FC     = 1 << NF;
`ifdef LRF_SEQ_FLUSH_EN
  localparam int STUCK   = 0;
  localparam int BUBBLES = 3;
`else
  localparam int STUCK   = D;
  localparam int BUBBLES = 0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          s_areset;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          dp_advance;
  logic          dp_in_valid;
  logic [DW-1:0] dp_in_data;
  logic [0:0]    dp_frame_idx;
  logic [1:0]    dp_beat_idx;
  logic          dp_first;
  logic [DW-1:0] dp_result;
  logic          err_framing;

  exp_t          sb[$];
  logic [DW-1:0] dp_pipe [D];
  int            checks = 0;
  int            passed = 0;
  int            n_acc = 0;
  int            out_count = 0;
  int            last_count = 0;
  int            bubble_count = 0;
  int            rdy_mode = 0;

  lrf_fuse_seq #(
    .PIXELS_PER_BEAT(PPB), .CHANNELS(CH), .IMAGE_DIM(DIM),
    .N_FUSE_COUNT(NF), .PIPELINE_DELAY(D), .OUT_FIFO_DEPTH(DEPTH)
  ) dut (
    .s_axis_aclk(clk), .s_axis_areset(s_areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast),
    .dp_advance(dp_advance), .dp_in_valid(dp_in_valid), .dp_in_data(dp_in_data),
    .dp_frame_idx(dp_frame_idx), .dp_beat_idx(dp_beat_idx), .dp_first(dp_first),
    .dp_result(dp_result), .err_framing(err_framing)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: the input data, delayed by D advances.
  always @(posedge clk) begin
    if (dp_advance) begin
      for (int i = D - 1; i > 0; i--) dp_pipe[i] <= dp_pipe[i-1];
      dp_pipe[0] <= dp_in_data;
    end
  end
  assign dp_result = dp_pipe[D-1];

  // Output-side ready: 0 = always ready, 1 = held off, 2 = random.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      m_tready = 1'b1;
    else if (rdy_mode == 1) m_tready = 1'b0;
    else                    m_tready = 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every output handshake pops one expected entry.
  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL out_unexpected: got data %0h with no expected entry", m_tdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("out_data", m_tdata, e.data);
        checkOutput("out_last", DW'(m_tlast), DW'(e.last));
      end
      out_count++;
      if (m_tlast) last_count++;
    end
    if (dp_advance && !dp_in_valid) bubble_count++;
  end

  function automatic logic [DW-1:0] rndData();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one beat and wait (bounded) for it to be accepted. On acceptance, the
  // window position of the beat decides whether it is expected at the output.
  task automatic applyStimulus(input logic [DW-1:0] d, input logic l);
    int  waitc = 0;
    bit  done = 0;
    int  beat, frame;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (s_tready) begin
        beat  = n_acc % BEATS;
        frame = (n_acc / BEATS) % FC;
        checkOutput("beat_idx", DW'(dp_beat_idx), DW'(beat));
        checkOutput("frame_idx", DW'(dp_frame_idx), DW'(frame));
        checkOutput("dp_first", DW'(dp_first), DW'(frame == 0));
        checkOutput("dp_in_data", dp_in_data, d);
        checkOutput("dp_in_valid", DW'(dp_in_valid), DW'(1));
        if (frame == FC - 1) sb.push_back('{data: d, last: (beat == BEATS - 1)});
        n_acc++;
        done = 1;
      end else if (++waitc > 200) begin
        checks++;
        $display("[TB] FAIL accept_timeout: got no accept after %0d cycles expected accept", waitc);
        done = 1;
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic sendFrame(input int gap_pct);
    for (int b = 0; b < BEATS; b++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
      applyStimulus(rndData(), b == BEATS - 1);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic doReset();
    s_tvalid = 1'b0;
    s_areset = 1'b1;
    idle(2);
    s_areset = 1'b0;
    sb.delete();
    n_acc = 0;
  endtask

  initial begin
    int oc, lc, bc, stall_seen;
    logic [DW-1:0] held;
    s_areset = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    idle(3);

    // Reset state
    @(negedge clk);
    checkOutput("rst_s_tready", DW'(s_tready), DW'(0));
    checkOutput("rst_m_tvalid", DW'(m_tvalid), DW'(0));
    checkOutput("rst_m_tlast", DW'(m_tlast), DW'(0));
    checkOutput("rst_m_tdata", m_tdata, '0);
    checkOutput("rst_err", DW'(err_framing), DW'(0));
    checkOutput("rst_advance", DW'(dp_advance), DW'(0));
    checkOutput("rst_frame_idx", DW'(dp_frame_idx), DW'(0));
    checkOutput("rst_beat_idx", DW'(dp_beat_idx), DW'(0));
    @(posedge clk); #1;
    s_areset = 1'b0;
    $display("[TB] streaming two windows");
    rdy_mode = 0;
    oc = out_count; lc = last_count; bc = bubble_count;
    for (int f = 0; f < 4; f++) sendFrame(0);
    idle(20);
    checkOutput("stream_outputs", DW'(out_count - oc), DW'(2 * BEATS - STUCK));
    checkOutput("stream_lasts", DW'(last_count - lc), DW'(STUCK == 0 ? 2 : 1));
    checkOutput("stream_bubbles", DW'(bubble_count - bc), DW'(BUBBLES));

    $display("[TB] flush after two frames");
    doReset();
    oc = out_count; bc = bubble_count;
    for (int f = 0; f < 2; f++) sendFrame(0);
    idle(20);
    checkOutput("flush_outputs", DW'(out_count - oc), DW'(BEATS - STUCK));
    checkOutput("flush_bubbles", DW'(bubble_count - bc), DW'(BUBBLES));

    $display("[TB] backpressure");
    doReset();
    rdy_mode = 1;
    m_tready = 1'b0;
    for (int k = 0; k < 4 * BEATS - 1; k++) applyStimulus(rndData(), (k % BEATS) == BEATS - 1);
    held = rndData();
    s_tdata = held; s_tlast = 1'b1; s_tvalid = 1'b1;
    stall_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (s_tready || dp_advance) stall_seen++;
      @(posedge clk); #1;
    end
    checkOutput("stall_ready_low", DW'(stall_seen), DW'(0));
    checkOutput("stall_fifo_valid", DW'(m_tvalid), DW'(1));
    rdy_mode = 0;
    m_tready = 1'b1;
    applyStimulus(held, 1'b1);
    idle(20);
    checkOutput("bp_residual", DW'(sb.size()), DW'(STUCK));

    $display("[TB] framing error");
    doReset();
    applyStimulus(rndData(), 1'b0);
    applyStimulus(rndData(), 1'b0);
    checkOutput("err_clean", DW'(err_framing), DW'(0));
    applyStimulus(rndData(), 1'b1);
    checkOutput("err_set", DW'(err_framing), DW'(1));
    applyStimulus(rndData(), 1'b1);
    sendFrame(0);
    checkOutput("err_sticky", DW'(err_framing), DW'(1));
    idle(20);

    $display("[TB] reset mid-frame");
    doReset();
    rdy_mode = 1;
    m_tready = 1'b0;
    for (int f = 0; f < 3; f++) sendFrame(0);
    for (int b = 0; b < 3; b++) applyStimulus(rndData(), 1'b0);
    @(negedge clk);
    checkOutput("pre_rst_m_tvalid", DW'(m_tvalid), DW'(1));
    @(posedge clk); #1;
    s_areset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("mid_rst_m_tvalid", DW'(m_tvalid), DW'(0));
    checkOutput("mid_rst_m_tdata", m_tdata, '0);
    checkOutput("mid_rst_s_tready", DW'(s_tready), DW'(0));
    @(posedge clk); #1;
    s_areset = 1'b0;
    sb.delete();
    n_acc = 0;
    rdy_mode = 0;
    m_tready = 1'b1;
    for (int f = 0; f < 2; f++) sendFrame(0);
    idle(20);
    checkOutput("rst_residual", DW'(sb.size()), DW'(STUCK));

    $display("[TB] randomized traffic");
    doReset();
    rdy_mode = 2;
    for (int f = 0; f < 8; f++) sendFrame(25);
    rdy_mode = 0;
    idle(40);
    checkOutput("rand_residual", DW'(sb.size()), DW'(STUCK));
    checkOutput("rand_err", DW'(err_framing), DW'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
